// File: rtl/mmio_timer_core_if.sv
// Basic MMIO slot bus: chip-select qualified read/write strobes with
// combinational read data returned by the responder.
interface mmio_timer_core_if;
  logic        cs;
  logic        read;
  logic        write;
  logic [4:0]  addr;
  logic [31:0] wr_data;
  logic [31:0] rd_data;

  modport master (output cs, read, write, addr, wr_data, input rd_data);
  modport slave  (input cs, read, write, addr, wr_data, output rd_data);
endinterface

// File: rtl/mmio_timer_core.sv
// 48-bit prescaled timer with compare match (one-shot or periodic),
// sticky match flag and level interrupt, accessed as an MMIO slot.
module mmio_timer_core (
  input  logic                clk,
  input  logic                reset,
  mmio_timer_core_if.slave    bus,
  output logic                irq
);
  localparam int W_CNT = 48;

  localparam logic [2:0] A_CTRL   = 3'd0;
  localparam logic [2:0] A_PRESC  = 3'd1;
  localparam logic [2:0] A_CNT_LO = 3'd2;
  localparam logic [2:0] A_CNT_HI = 3'd3;
  localparam logic [2:0] A_CMP_LO = 3'd4;
  localparam logic [2:0] A_CMP_HI = 3'd5;
  localparam logic [2:0] A_STATUS = 3'd6;
  localparam logic [2:0] A_CLEAR  = 3'd7;

  // ctrl bits: [0] en, [1] periodic, [2] irq_en
  logic [2:0]       ctrl_q, ctrl_d;
  logic [15:0]      prescale_q, prescale_d;
  logic [W_CNT-1:0] cmp_q, cmp_d;
  logic [W_CNT-1:0] count_q, count_d;
  logic [15:0]      pre_q, pre_d;
  logic [15:0]      snap_hi_q, snap_hi_d;
  logic             flag_q, flag_d;

  logic       wr_en, rd_en, tick, clr, hit;
  logic [2:0] a;
  logic       unused_addr_hi;

  assign a              = bus.addr[2:0];
  assign unused_addr_hi = ^bus.addr[4:3];

  // Decode bus strobes and timer events from current state
  always_comb begin
    wr_en = bus.cs & bus.write;
    rd_en = bus.cs & bus.read;
    tick  = ctrl_q[0] & (pre_q == prescale_q);
    clr   = wr_en & (a == A_CLEAR);
    // a CLEAR write suppresses match evaluation in its cycle
    hit   = tick & ~clr & (count_q == cmp_q);
  end

  // Next-state: timer advance first, then bus writes layered on top so
  // that bus writes win where they collide (except W1C vs match set)
  always_comb begin
    ctrl_d     = ctrl_q;
    prescale_d = prescale_q;
    cmp_d      = cmp_q;
    count_d    = count_q;
    pre_d      = pre_q;
    snap_hi_d  = snap_hi_q;
    flag_d     = flag_q;

    if (clr) begin
      count_d = '0;
      pre_d   = '0;
    end else if (ctrl_q[0]) begin
      pre_d = tick ? 16'd0 : pre_q + 16'd1;
      if (tick) begin
        if (hit && ctrl_q[1]) count_d = '0;
        else                  count_d = count_q + 48'd1;
      end
    end

    if (hit && !ctrl_q[1]) ctrl_d[0] = 1'b0;

    if (wr_en && a == A_STATUS && bus.wr_data[0]) flag_d = 1'b0;
    if (hit) flag_d = 1'b1;

    if (wr_en) begin
      case (a)
        A_CTRL:   ctrl_d            = bus.wr_data[2:0];
        A_PRESC:  prescale_d        = bus.wr_data[15:0];
        A_CMP_LO: cmp_d[31:0]       = bus.wr_data;
        A_CMP_HI: cmp_d[47:32]      = bus.wr_data[15:0];
        default:  ;
      endcase
    end

    // snapshot the upper count bits as the LO read completes
    if (rd_en && a == A_CNT_LO) snap_hi_d = count_q[47:32];
  end

  // State registers with synchronous reset
  always_ff @(posedge clk) begin
    if (reset) begin
      ctrl_q     <= '0;
      prescale_q <= '0;
      cmp_q      <= '0;
      count_q    <= '0;
      pre_q      <= '0;
      snap_hi_q  <= '0;
      flag_q     <= 1'b0;
    end else begin
      ctrl_q     <= ctrl_d;
      prescale_q <= prescale_d;
      cmp_q      <= cmp_d;
      count_q    <= count_d;
      pre_q      <= pre_d;
      snap_hi_q  <= snap_hi_d;
      flag_q     <= flag_d;
    end
  end

  // Zero-latency read mux, zero when not selected for read
  always_comb begin
    bus.rd_data = '0;
    if (rd_en) begin
      case (a)
        A_CTRL:   bus.rd_data = {29'd0, ctrl_q};
        A_PRESC:  bus.rd_data = {16'd0, prescale_q};
        A_CNT_LO: bus.rd_data = count_q[31:0];
        A_CNT_HI: bus.rd_data = {16'd0, snap_hi_q};
        A_CMP_LO: bus.rd_data = cmp_q[31:0];
        A_CMP_HI: bus.rd_data = {16'd0, cmp_q[47:32]};
        A_STATUS: bus.rd_data = {31'd0, flag_q};
        default:  bus.rd_data = '0;
      endcase
    end
  end

  assign irq = flag_q & ctrl_q[2];
endmodule

// File: tb/tb_mmio_timer_core.sv
// Self-checking bench for mmio_timer_core: lockstep behavioural model,
// directed scenarios and a randomized bus-traffic phase.
module tb_mmio_timer_core;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic irq;
  always #5 clk = ~clk;

  mmio_timer_core_if bus();
  mmio_timer_core dut (.clk(clk), .reset(reset), .bus(bus), .irq(irq));

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // ---------------- behavioural reference model ----------------
  bit          m_en, m_per, m_ie, m_flag;
  logic [15:0] m_ps, m_pre, m_snap;
  logic [47:0] m_cmp, m_cnt;

  function automatic logic [31:0] m_read(input logic [2:0] a);
    case (a)
      3'd0: return {29'd0, m_ie, m_per, m_en};
      3'd1: return {16'd0, m_ps};
      3'd2: return m_cnt[31:0];
      3'd3: return {16'd0, m_snap};
      3'd4: return m_cmp[31:0];
      3'd5: return {16'd0, m_cmp[47:32]};
      3'd6: return {31'd0, m_flag};
      default: return 32'd0;
    endcase
  endfunction

  // Apply one clock edge of the timer's documented behaviour.
  task automatic m_clock(input bit rst, input bit cs, rd, wr,
                         input logic [2:0] a, input logic [31:0] d);
    bit fire, clear, match;
    if (rst) begin
      {m_en, m_per, m_ie, m_flag} = '0;
      m_ps = '0; m_pre = '0; m_snap = '0; m_cmp = '0; m_cnt = '0;
      return;
    end
    fire  = m_en && (m_pre == m_ps);
    clear = cs && wr && a == 3'd7;
    match = fire && !clear && (m_cnt == m_cmp);
    if (cs && rd && a == 3'd2) m_snap = m_cnt[47:32];
    if (clear) begin
      m_cnt = 0; m_pre = 0;
    end else if (m_en) begin
      if (fire) begin
        m_pre = 0;
        m_cnt = (match && m_per) ? 48'd0 : m_cnt + 48'd1;
      end else m_pre = m_pre + 16'd1;
    end
    if (match && !m_per) m_en = 0;
    if (cs && wr && a == 3'd6 && d[0]) m_flag = 0;
    if (match) m_flag = 1;
    if (cs && wr) begin
      case (a)
        3'd0: {m_ie, m_per, m_en} = d[2:0];
        3'd1: m_ps = d[15:0];
        3'd4: m_cmp[31:0] = d;
        3'd5: m_cmp[47:32] = d[15:0];
        default: ;
      endcase
    end
  endtask

  // One bus cycle: drive at negedge, check outputs, pass the edge, step model.
  task automatic step(input bit rst, input bit cs, rd, wr, input logic [4:0] a,
                      input logic [31:0] d, output logic [31:0] rdv);
    reset = rst; bus.cs = cs; bus.read = rd; bus.write = wr;
    bus.addr = a; bus.wr_data = d;
    #1;
    rdv = bus.rd_data;
    if (!rst) begin
      chk($sformatf("rd_data a%0d", a[2:0]), bus.rd_data, (cs && rd) ? m_read(a[2:0]) : 32'd0);
      chk("irq", irq, m_flag & m_ie);
    end
    @(posedge clk);
    m_clock(rst, cs, rd, wr, a[2:0], d);
    @(negedge clk);
  endtask

  logic [31:0] v;

  task automatic idle();
    logic [31:0] x;
    step(0, 0, 0, 0, 5'd0, 32'd0, x);
  endtask
  task automatic wr_reg(input logic [2:0] a, input logic [31:0] d);
    logic [31:0] x;
    step(0, 1, 0, 1, {2'($urandom_range(0, 3)), a}, d, x);
  endtask
  task automatic rd_reg(input logic [2:0] a, output logic [31:0] r);
    step(0, 1, 1, 0, {2'($urandom_range(0, 3)), a}, 32'd0, r);
  endtask
  task automatic do_reset();
    logic [31:0] x;
    step(1, 1, 0, 1, 5'd7, 32'hFFFF_FFFF, x);
  endtask

  // Count edges until irq rises (bounded).
  task automatic wait_irq(output int n);
    n = 0;
    while (!irq && n < 200) begin idle(); n++; end
  endtask

  // Advance until the next edge is a tick (optionally a matching tick).
  task automatic to_tick(input bit need_match, output bit ok);
    ok = 0;
    for (int i = 0; i < 200; i++) begin
      if (m_en && m_pre == m_ps && (!need_match || m_cnt == m_cmp)) begin ok = 1; break; end
      idle();
    end
  endtask

  initial begin
    int n, mx;
    bit ok;
    logic [31:0] lo, hi;
    bus.cs = 0; bus.read = 0; bus.write = 0; bus.addr = 0; bus.wr_data = 0;
    m_clock(1, 0, 0, 0, 3'd0, 32'd0);
    @(negedge clk);
    do_reset(); do_reset();

    // reset state
    for (int i = 0; i < 8; i++) begin
      rd_reg(3'(i), v);
      chk($sformatf("reset_rd%0d", i), v, 32'd0);
    end
    chk("reset_irq", irq, 1'b0);
    step(0, 0, 1, 1, 5'd7, 32'd1, v);
    chk("cs0_rd", v, 32'd0);

    // register masking
    wr_reg(3'd1, 32'hFFFF_0005); rd_reg(3'd1, v); chk("presc_mask", v, 32'd5);
    wr_reg(3'd5, 32'hABCD_1234); rd_reg(3'd5, v); chk("cmphi_mask", v, 32'h1234);
    wr_reg(3'd0, 32'hFFFF_FFF8); rd_reg(3'd0, v); chk("ctrl_mask", v, 32'd0);
    wr_reg(3'd2, 32'h55);        rd_reg(3'd2, v); chk("ro_cnt", v, 32'd0);

    // periodic: PRESCALE=3, CMP=4 -> period 20
    do_reset();
    wr_reg(3'd1, 32'd3); wr_reg(3'd4, 32'd4); wr_reg(3'd5, 32'd0);
    wr_reg(3'd0, 32'd7);
    wait_irq(n); chk("per_first", n, 20);
    wr_reg(3'd6, 32'd1);
    wait_irq(n); chk("per_second", n, 19);
    mx = 0;
    for (int i = 0; i < 40; i++) begin
      rd_reg(3'd2, v); if (int'(v) > mx) mx = int'(v);
    end
    chk("per_cnt_max", mx, 4);

    // one-shot: PRESCALE=0, CMP=2
    do_reset();
    wr_reg(3'd4, 32'd2); wr_reg(3'd0, 32'd5);
    wait_irq(n); chk("os_ticks", n, 3);
    rd_reg(3'd0, v); chk("os_ctrl", v, 32'd4);
    rd_reg(3'd2, v); chk("os_cnt", v, 32'd3);
    repeat (5) idle();
    rd_reg(3'd2, v); chk("os_hold", v, 32'd3);

    // snapshot coherence while running
    do_reset();
    wr_reg(3'd5, 32'd1); wr_reg(3'd0, 32'd1);
    repeat ($urandom_range(3, 30)) idle();
    rd_reg(3'd2, lo); rd_reg(3'd3, hi);
    chk("snap_hi", hi, 32'd0);
    chk("snap_lo_run", (lo > 32'd2), 1'b1);

    // collisions: PRESCALE=1, CMP=3, periodic, no irq
    do_reset();
    wr_reg(3'd1, 32'd1); wr_reg(3'd4, 32'd3); wr_reg(3'd0, 32'd3);
    to_tick(1, ok); chk("col_w1c_reach", ok, 1'b1);
    wr_reg(3'd6, 32'd1);
    rd_reg(3'd6, v); chk("col_w1c_flag", v, 32'd1);
    wr_reg(3'd6, 32'd1);
    to_tick(1, ok); chk("col_clr_reach", ok, 1'b1);
    wr_reg(3'd7, 32'd0);
    rd_reg(3'd6, v); chk("col_clr_nomatch", v, 32'd0);
    rd_reg(3'd2, v); chk("col_clr_cnt", v, 32'd0);
    to_tick(1, ok); chk("col_cmp_reach", ok, 1'b1);
    wr_reg(3'd4, 32'd0);
    rd_reg(3'd6, v); chk("col_cmp_old", v, 32'd1);
    rd_reg(3'd2, v); chk("col_cmp_wrap", v, 32'd0);

    // randomized traffic against the model
    do_reset();
    for (int i = 0; i < 600; i++) begin
      int t;
      logic [2:0] a;
      logic [31:0] d;
      t = $urandom_range(0, 9);
      a = 3'($urandom_range(0, 7));
      d = $urandom;
      case (a)
        3'd0: d = {$urandom_range(0, 15) == 0 ? 29'd0 : 29'($urandom), 1'b1, d[1:0]};
        3'd1: d = 32'($urandom_range(0, 3));
        3'd4: d = 32'($urandom_range(0, 15));
        3'd5: d = ($urandom_range(0, 7) == 0) ? d : 32'd0;
        3'd7: if ($urandom_range(0, 3) != 0) a = 3'd2;
        default: ;
      endcase
      if (t < 4)      idle();
      else if (t < 7) rd_reg(a, v);
      else if (t < 9) wr_reg(a, d);
      else            step(0, 1, 1, 1, {2'b00, a}, d, v);
    end

    // reset mid-period with irq asserted
    do_reset();
    wr_reg(3'd1, 32'd2); wr_reg(3'd4, 32'd5); wr_reg(3'd0, 32'd7);
    wait_irq(n); chk("rst_irq_up", irq, 1'b1);
    idle();
    do_reset();
    chk("rst_irq_drop", irq, 1'b0);
    for (int i = 0; i < 8; i++) begin
      rd_reg(3'(i), v);
      chk($sformatf("rst_rd%0d", i), v, 32'd0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
